// File: rtl/pipe_skid_reg.sv
// Two-entry skid stage register: registered in_ready, one beat per cycle under backpressure.
// Optional stall counter port enabled by defining PIPE_SKID_STATS_EN.
module pipe_skid_reg #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    // Bit 1 is skid_valid, bit 0 is main_valid; 2'b10 is never produced.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept_c;
    logic             drain_c;

    assign out_valid = state_q[0];
    assign in_ready  = ~state_q[1];
    assign out_data  = main_q;

    assign accept_c = in_valid & in_ready;
    assign drain_c  = out_valid & out_ready;

    // Next-state and data steering; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept_c && drain_c) begin
                        main_d = in_data;
                    end else if (accept_c) begin
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end else if (drain_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain_c) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_SKID_STATS_EN
    localparam int unsigned CNT_W = 32;

    logic [CNT_W-1:0] stall_q, stall_d;

    // Saturating count of cycles where a held beat is refused downstream.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue-based reference model checked every cycle plus directed literals.
`timescale 1ns/1ps
module tb_pipe_skid_reg;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [63:0] in_data   = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
`ifdef PIPE_SKID_STATS_EN
    logic [31:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [63:0] mq[$];
    logic [31:0] mstall = '0;

    pipe_skid_reg #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_SKID_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the block is a FIFO of capacity two whose head is the output.
    always @(posedge clk or negedge reset) begin
        logic acc, drn;
        if (!reset) begin
            mq.delete();
            mstall = '0;
        end else begin
            acc = in_valid && (mq.size() < 2);
            drn = (mq.size() > 0) && out_ready;
            if ((mq.size() > 0) && !out_ready && (mstall != 32'hFFFF_FFFF)) mstall++;
            if (flush) begin
                mq.delete();
            end else begin
                if (drn) void'(mq.pop_front());
                if (acc) mq.push_back(in_data);
            end
        end
        #1;
        chk("model_out_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("model_in_ready", 64'(in_ready), 64'(mq.size() < 2));
        if (mq.size() > 0) chk("model_out_data", out_data, mq[0]);
        if (!out_valid && !in_ready) chk("illegal_state", 64'(1), 64'(0));
`ifdef PIPE_SKID_STATS_EN
        chk("model_stall_cnt", 64'(stall_cnt), 64'(mstall));
`endif
    end

    // Drive one cycle of inputs at the falling edge and return just after the next rising edge.
    task automatic tick(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        do_reset();
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_data", out_data, 64'd0);

        // Streaming at full rate
        tick(1'b1, 64'd1, 1'b1, 1'b0);
        chk("stream_d0", out_data, 64'd1);
        tick(1'b1, 64'd13, 1'b1, 1'b0);
        chk("stream_d1", out_data, 64'd13);
        chk("stream_rdy", 64'(in_ready), 64'd1);
        tick(1'b1, 64'd1309, 1'b1, 1'b0);
        chk("stream_d2", out_data, 64'd1309);
        chk("stream_rdy2", 64'(in_ready), 64'd1);
        tick(1'b0, 64'd0, 1'b1, 1'b0);
        chk("stream_empty", 64'(out_valid), 64'd0);

        // Backpressure fills the skid register
        tick(1'b1, 64'hA, 1'b0, 1'b0);
        chk("bp_one_data", out_data, 64'hA);
        chk("bp_one_rdy", 64'(in_ready), 64'd1);
        tick(1'b1, 64'hB, 1'b0, 1'b0);
        chk("bp_full_rdy", 64'(in_ready), 64'd0);
        chk("bp_full_data", out_data, 64'hA);
        tick(1'b1, 64'hC, 1'b0, 1'b0);
        chk("bp_hold_data", out_data, 64'hA);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        tick(1'b0, 64'd0, 1'b1, 1'b0);
        chk("bp_drain_data", out_data, 64'hB);
        chk("bp_drain_rdy", 64'(in_ready), 64'd1);
        tick(1'b0, 64'd0, 1'b1, 1'b0);
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Flush from FULL discards the same-cycle beat
        tick(1'b1, 64'hA, 1'b0, 1'b0);
        tick(1'b1, 64'hB, 1'b0, 1'b0);
        tick(1'b1, 64'hC, 1'b0, 1'b1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_rdy", 64'(in_ready), 64'd1);
        tick(1'b0, 64'd0, 1'b1, 1'b0);
        chk("flush_no_c", 64'(out_valid), 64'd0);

        // Asynchronous reset while FULL
        tick(1'b1, 64'h11, 1'b0, 1'b0);
        tick(1'b1, 64'h22, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("mid_reset_valid", 64'(out_valid), 64'd0);
        chk("mid_reset_rdy", 64'(in_ready), 64'd1);
        chk("mid_reset_data", out_data, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick(1'b1, 64'h7, 1'b1, 1'b0);
        chk("post_reset_data", out_data, 64'h7);
        tick(1'b0, 64'd0, 1'b1, 1'b0);

`ifdef PIPE_SKID_STATS_EN
        do_reset();
        tick(1'b1, 64'h5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 64'd0, 1'b0, 1'b0);
        chk("stall_five", 64'(stall_cnt), 64'd5);
        tick(1'b0, 64'd0, 1'b1, 1'b1);
        chk("stall_after_flush", 64'(stall_cnt), 64'd5);
`endif

        // Random traffic against the reference queue
        for (int i = 0; i < 10000; i++) begin
            tick(1'($urandom_range(0, 1)), {$urandom, $urandom},
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
